// File: rtl/ivx_sequencer.sv
// ivx_sequencer: four-phase program sequencer with page register, CALL/RET
// return stack and optional memory wait states.
// Optional feature macro: IVX_WAIT_EN (ready_i low holds phase 3).
module ivx_sequencer #(
   parameter int AW          = 13,
   parameter int STACK_DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [15:0]   instr_i,
   input  logic [7:0]    src_value_i,
   input  logic          ready_i,
   output logic [AW-1:0] A,
   output logic [15:0]   instr_o,
   output logic [1:0]    phase_o,
   output logic          mclk_o,
   output logic          stk_ovf_o,
   output logic          stk_unf_o
);

   // page is only meaningful above 13 address bits; keep one dummy bit otherwise
   localparam int PW  = (AW > 13) ? AW - 13 : 1;
   localparam int IW  = $clog2(STACK_DEPTH);
   localparam int SPW = IW + 1;

   typedef enum logic [1:0] {
      PH_FETCH = 2'd0,
      PH_EXEC  = 2'd1,
      PH_ADDR  = 2'd2,
      PH_MEM   = 2'd3
   } phase_t;

   phase_t         phase_q, phase_d;
   logic [AW-1:0]  pc_q, pc_d;
   logic [AW-1:0]  a_q, a_d;
   logic [AW-1:0]  xtgt_q, xtgt_d;
   logic [PW-1:0]  page_q, page_d;
   logic [15:0]    instr_q, instr_d;
   logic [SPW-1:0] sp_q, sp_d;
   logic [IW-1:0]  wp_q, wp_d;
   logic [AW-1:0]  stk_q [STACK_DEPTH];
   logic [AW-1:0]  stk_d [STACK_DEPTH];
   logic           mclk_q, mclk_d;
   logic           ovf_q, ovf_d;
   logic           unf_q, unf_d;

   // Decode of the latched instruction
   logic [2:0]    op;
   logic          is_call, is_ret, is_setpage, is_xec, stk_full;
   logic [AW-1:0] pc_inc, pg8_tgt, nzt_tgt, xec_tgt, jmp_tgt;
   logic [4:0]    xsum5;
   logic [7:0]    xsum8;
   logic [IW-1:0] pop_idx;

   assign op         = instr_q[15:13];
   assign is_call    = (instr_q[15:8] == 8'hC9);
   assign is_ret     = (instr_q[15:8] == 8'hCD);
   assign is_setpage = (instr_q[15:8] == 8'hCE);
   assign is_xec     = (op == 3'b100);
   assign stk_full   = (sp_q == SPW'(STACK_DEPTH));
   assign pop_idx    = wp_q - IW'(1);

   assign pc_inc  = pc_q + AW'(1);
   assign pg8_tgt = {pc_q[AW-1:8], instr_q[7:0]};
   assign nzt_tgt = instr_q[12] ? {pc_q[AW-1:5], instr_q[4:0]} : pg8_tgt;
   // XEC offsets wrap inside their field; no carry into the upper PC bits
   assign xsum5   = src_value_i[4:0] + instr_q[4:0];
   assign xsum8   = src_value_i + instr_q[7:0];
   assign xec_tgt = instr_q[12] ? {pc_q[AW-1:5], xsum5} : {pc_q[AW-1:8], xsum8};

   if (AW > 13) begin : g_page
      assign jmp_tgt = {page_q, instr_q[12:0]};
   end else begin : g_nopage
      logic unused_page;
      assign jmp_tgt     = instr_q[12:0];
      assign unused_page = ^page_q;
   end

`ifndef IVX_WAIT_EN
   logic unused_ready;
   assign unused_ready = ready_i;
`endif

   // Next-state logic for the phase machine, PC, address, stack and flags
   always_comb begin
      phase_d = phase_q;
      pc_d    = pc_q;
      a_d     = a_q;
      xtgt_d  = xtgt_q;
      page_d  = page_q;
      instr_d = instr_q;
      sp_d    = sp_q;
      wp_d    = wp_q;
      stk_d   = stk_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      unique case (phase_q)
         PH_FETCH: begin
            instr_d = instr_i;
            phase_d = PH_EXEC;
         end
         PH_EXEC: begin
            phase_d = PH_ADDR;
            if (is_call) begin
               // circular stack: a push while full overwrites the oldest slot
               stk_d[wp_q] = pc_inc;
               wp_d        = wp_q + IW'(1);
               if (stk_full) ovf_d = 1'b1;
               else          sp_d  = sp_q + SPW'(1);
               pc_d = pg8_tgt;
            end else if (is_ret) begin
               if (sp_q == '0) begin
                  unf_d = 1'b1;
                  pc_d  = pc_inc;
               end else begin
                  wp_d = pop_idx;
                  sp_d = sp_q - SPW'(1);
                  pc_d = stk_q[pop_idx];
               end
            end else if (is_setpage) begin
               if (AW > 13) page_d = instr_q[PW-1:0];
               pc_d = pc_inc;
            end else begin
               case (op)
                  3'b111:  pc_d   = jmp_tgt;
                  3'b101:  pc_d   = (src_value_i != 8'd0) ? nzt_tgt : pc_inc;
                  3'b100:  xtgt_d = xec_tgt;  // PC held so execution resumes at XEC+1
                  default: pc_d   = pc_inc;
               endcase
            end
         end
         PH_ADDR: begin
            a_d     = is_xec ? xtgt_q : pc_q;
            phase_d = PH_MEM;
         end
         PH_MEM: begin
`ifdef IVX_WAIT_EN
            phase_d = ready_i ? PH_FETCH : PH_MEM;
`else
            phase_d = PH_FETCH;
`endif
         end
      endcase
      mclk_d = (phase_d == PH_MEM);
   end

   // State registers with synchronous active-low reset; stack contents dropped
   always_ff @(posedge clk) begin
      if (!reset) begin
         phase_q <= PH_FETCH;
         pc_q    <= '0;
         a_q     <= '0;
         xtgt_q  <= '0;
         page_q  <= '0;
         instr_q <= '0;
         sp_q    <= '0;
         wp_q    <= '0;
         mclk_q  <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
      end else begin
         phase_q <= phase_d;
         pc_q    <= pc_d;
         a_q     <= a_d;
         xtgt_q  <= xtgt_d;
         page_q  <= page_d;
         instr_q <= instr_d;
         sp_q    <= sp_d;
         wp_q    <= wp_d;
         mclk_q  <= mclk_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         stk_q   <= stk_d;
      end
   end

   assign A         = a_q;
   assign instr_o   = instr_q;
   assign phase_o   = phase_q;
   assign mclk_o    = mclk_q;
   assign stk_ovf_o = ovf_q;
   assign stk_unf_o = unf_q;

endmodule

// File: tb/tb_ivx_sequencer.sv
// Bench for ivx_sequencer: instruction-level model plus directed programs.
module tb_ivx_sequencer;
   localparam int AW  = 16;
   localparam int SD  = 4;
   localparam int MOD = 1 << AW;
`ifdef IVX_WAIT_EN
   localparam bit WAIT_EN = 1'b1;
`else
   localparam bit WAIT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset = 1'b0;
   logic rst13 = 1'b0;
   logic ready = 1'b1;

   logic [15:0] pmem [0:65535];
   logic [7:0]  smem [0:65535];

   logic [AW-1:0] A;
   logic [15:0]   instr_i, instr_o;
   logic [7:0]    src;
   logic [1:0]    phase;
   logic          mclk, ovf, unf;

   logic [12:0] A13;
   logic [15:0] instr13;
   logic [1:0]  phase13;
   logic        mclk13, ovf13, unf13;

   assign instr_i = pmem[A];
   assign src     = smem[A];

   ivx_sequencer #(.AW(AW), .STACK_DEPTH(SD)) dut (
      .clk(clk), .reset(reset), .instr_i(instr_i), .src_value_i(src), .ready_i(ready),
      .A(A), .instr_o(instr_o), .phase_o(phase), .mclk_o(mclk),
      .stk_ovf_o(ovf), .stk_unf_o(unf));

   ivx_sequencer #(.AW(13), .STACK_DEPTH(2)) dut13 (
      .clk(clk), .reset(rst13), .instr_i(16'h0000), .src_value_i(8'h00), .ready_i(1'b1),
      .A(A13), .instr_o(instr13), .phase_o(phase13), .mclk_o(mclk13),
      .stk_ovf_o(ovf13), .stk_unf_o(unf13));

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // ---------------- instruction-level model ----------------
   int          pc_m, fa_m, nxt_fa_m, page_m, ph_m, prev_m;
   int          stk_m[$];
   bit          ovf_m, unf_m;
   logic [15:0] ins_m;

   task automatic model_step();
      int op, j8, j5, s4, sv, xt;
      op = int'(ins_m[15:13]);
      j8 = int'(ins_m[7:0]);
      j5 = int'(ins_m[4:0]);
      s4 = int'(ins_m[12]);
      sv = int'(smem[fa_m]);
      xt = 0;
      if (ins_m[15:8] == 8'hC9) begin
         if (stk_m.size() == SD) begin
            void'(stk_m.pop_front());
            ovf_m = 1'b1;
         end
         stk_m.push_back((pc_m + 1) % MOD);
         pc_m = (pc_m & ~255) | j8;
      end else if (ins_m[15:8] == 8'hCD) begin
         if (stk_m.size() == 0) begin
            unf_m = 1'b1;
            pc_m  = (pc_m + 1) % MOD;
         end else pc_m = stk_m.pop_back();
      end else if (ins_m[15:8] == 8'hCE) begin
         page_m = j8 % (1 << (AW - 13));
         pc_m   = (pc_m + 1) % MOD;
      end else begin
         case (op)
            7: pc_m = page_m * 8192 + int'(ins_m[12:0]);
            5: if (sv != 0) pc_m = (s4 != 0) ? ((pc_m & ~31) | j5) : ((pc_m & ~255) | j8);
               else pc_m = (pc_m + 1) % MOD;
            4: xt = (s4 != 0) ? ((pc_m & ~31) | ((sv + j5) % 32))
                              : ((pc_m & ~255) | ((sv + j8) % 256));
            default: pc_m = (pc_m + 1) % MOD;
         endcase
      end
      nxt_fa_m = (op == 4) ? xt : pc_m;
   endtask

   logic rst_e = 1'b0, rdy_e = 1'b1, rst13_e = 1'b0;
   always @(posedge clk) begin
      rst_e   <= reset;
      rdy_e   <= ready;
      rst13_e <= rst13;
   end

   int ph13 = 0;
   int c13  = 0;

   // compare process: every negedge, both DUTs against their models
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_e) begin
            chk("rst phase", phase, 0);
            chk("rst A", A, 0);
            chk("rst instr", instr_o, 0);
            chk("rst mclk", mclk, 0);
            chk("rst ovf", ovf, 0);
            chk("rst unf", unf, 0);
            pc_m = 0; fa_m = 0; nxt_fa_m = 0; page_m = 0; ph_m = 0; prev_m = 0;
            stk_m.delete(); ovf_m = 1'b0; unf_m = 1'b0; ins_m = '0;
         end else begin
            prev_m = ph_m;
            if (ph_m == 3) ph_m = (WAIT_EN && !rdy_e) ? 3 : 0;
            else ph_m = ph_m + 1;
            if (ph_m == 1) ins_m = pmem[fa_m];
            if (ph_m == 2) model_step();
            if (ph_m == 3 && prev_m == 2) fa_m = nxt_fa_m;
            chk("phase", phase, ph_m);
            chk("mclk", mclk, (ph_m == 3) ? 1 : 0);
            chk("A", A, fa_m);
            if (ph_m != 0) chk("instr_o", instr_o, ins_m);
            chk("ovf", ovf, ovf_m);
            chk("unf", unf, unf_m);
         end
         if (!rst13_e) begin
            ph13 = 0;
            c13  = 0;
         end else begin
            ph13 = (ph13 + 1) % 4;
            chk("phase13", phase13, ph13);
            chk("mclk13", mclk13, (ph13 == 3) ? 1 : 0);
            if (ph13 == 3) begin
               chk("A13 seq", A13, (c13 + 1) % 8192);
               if (c13 == 8191) chk("A13 wrap", A13, 0);
               c13++;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic begin_prog();
      @(negedge clk);
      reset = 1'b0;
      ready = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 65536; i++) begin
         pmem[i] = '0;
         smem[i] = '0;
      end
   endtask

   task automatic release_rst();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      rst13 = 1'b1;
   endtask

   // advance to the phase-3 negedge of the next n machine cycles
   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         int t;
         t = 0;
         do begin
            @(negedge clk);
            t++;
         end while (phase !== 2'd2 && t < 64);
         if (t >= 64) begin
            tests++;
            fails++;
            $display("FAIL cycle timeout: phase %0d never reached 2", phase);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      bit alive;

      // SETPAGE then JMP in a wide address space
      begin_prog();
      pmem[0] = 16'hCE05;
      pmem[1] = 16'hE123;
      release_rst();
      cycles(1); chk("setpage A", A, 16'h0001);
      cycles(1); chk("jmp page A", A, 16'hA123);
      cycles(1); chk("after jmp A", A, 16'hA124);

      // NZT not taken
      begin_prog();
      pmem[0] = 16'hE210; pmem[16'h210] = 16'hA240; smem[16'h210] = 8'h00;
      release_rst();
      cycles(2); chk("nzt no-branch A", A, 16'h0211);

      // NZT taken, long form
      begin_prog();
      pmem[0] = 16'hE210; pmem[16'h210] = 16'hA240; smem[16'h210] = 8'h01;
      release_rst();
      cycles(2); chk("nzt j8 A", A, 16'h0240);

      // NZT taken, short form
      begin_prog();
      pmem[0] = 16'hE210; pmem[16'h210] = 16'hB01F; smem[16'h210] = 8'h01;
      release_rst();
      cycles(2); chk("nzt j5 A", A, 16'h021F);

      // XEC with in-page wrap landing on itself, then an ALU op there
      begin_prog();
      pmem[0] = 16'hE310; pmem[16'h310] = 16'h80F0; smem[16'h310] = 8'h20;
      release_rst();
      cycles(2); chk("xec wrap A", A, 16'h0310);
      @(posedge clk);
      #1 pmem[16'h310] = 16'h0000;
      cycles(1); chk("xec return A", A, 16'h0311);

      // XEC short form
      begin_prog();
      pmem[0] = 16'hE310; pmem[16'h310] = 16'h901E; smem[16'h310] = 8'h05;
      release_rst();
      cycles(2); chk("xec j5 A", A, 16'h0303);
      cycles(1); chk("xec j5 return A", A, 16'h0311);

      // CALL x5 (overflow), RET x5 (underflow on the last)
      begin_prog();
      pmem[16'h00] = 16'hC910; pmem[16'h10] = 16'hC920; pmem[16'h20] = 16'hC930;
      pmem[16'h30] = 16'hC940; pmem[16'h40] = 16'hC950;
      pmem[16'h50] = 16'hCD00; pmem[16'h41] = 16'hCD00; pmem[16'h31] = 16'hCD00;
      pmem[16'h21] = 16'hCD00; pmem[16'h11] = 16'hCD00; pmem[16'h13] = 16'hC0AA;
      release_rst();
      cycles(4); chk("4 calls A", A, 16'h0040); chk("4 calls ovf", ovf, 0);
      cycles(1); chk("5 calls A", A, 16'h0050); chk("5 calls ovf", ovf, 1);
      cycles(1); chk("ret1 A", A, 16'h0041);
      cycles(1); chk("ret2 A", A, 16'h0031);
      cycles(1); chk("ret3 A", A, 16'h0021);
      cycles(1); chk("ret4 A", A, 16'h0011); chk("ret4 unf", unf, 0);
      cycles(1); chk("ret5 A", A, 16'h0012); chk("ret5 unf", unf, 1);
      cycles(1); chk("after unf A", A, 16'h0013);
      cycles(1); chk("xmit A", A, 16'h0014);

      // wait states, then reset while phase 3 is held
      begin_prog();
      release_rst();
      cycles(1); chk("wait pre A", A, 16'h0001);
      ready = 1'b0;
      cnt   = 1;
      alive = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (alive && phase == 2'd3) begin
            cnt++;
            chk("wait A hold", A, 16'h0001);
            chk("wait mclk hold", mclk, 1);
         end else alive = 1'b0;
      end
      ready = 1'b1;
      @(negedge clk);
      if (alive && phase == 2'd3) cnt++;
      chk("cycle length", cnt + 3, WAIT_EN ? 7 : 4);
      cycles(1);
      ready = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("reset in ph3 phase", phase, 0);
      chk("reset in ph3 A", A, 0);
      ready = 1'b1;
      reset = 1'b1;
      cycles(1); chk("after reset A", A, 16'h0001);

      // let the 13-bit instance wrap its address
      for (int t = 0; t < 40000 && c13 <= 8193; t++) @(negedge clk);
      chk("A13 wrap reached", (c13 > 8193) ? 1 : 0, 1);
      chk("A13 ovf", ovf13, 0);
      chk("A13 unf", unf13, 0);
      chk("A13 instr", instr13, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/ivx_sequencer.md
# ivx_sequencer

Parametrised program sequencer for the next-generation 8X305-style core. It owns the four-phase machine cycle, the program counter, JMP/NZT/XEC address generation and instruction latching. It adds three things the first-generation core lacks: a page register for address spaces wider than 13 bits, a hardware CALL/RET stack, and memory wait states. It sits between program memory and the datapath. The datapath supplies operand values and treats the sequencer commands as no-ops.

## Interface
- `AW`, default 13: program address width; legal range 13..16.
- `STACK_DEPTH`, default 4: number of return-stack entries; must be a power of two, at least 2.
- `clk` input 1: machine clock; every state change happens on its rising edge.
- `reset` input 1: reset, synchronous, active-low.
- `instr_i` input 16: program memory data, sampled at the end of phase 0.
- `src_value_i` input 8: operand value from the datapath (rotated and masked). Sampled at the end of phase 1.
- `ready_i` input 1: program memory ready; only used when wait states are compiled in.
- `A` output AW: program address, registered.
- `instr_o` output 16: latched instruction, stable during phases 1–3.
- `phase_o` output 2: current phase, 0..3.
- `mclk_o` output 1: high while `phase_o==3`.
- `stk_ovf_o` output 1: sticky flag, set on push while the stack is full.
- `stk_unf_o` output 1: sticky flag, set on pop while the stack is empty.

## Operation
- **Decode:** `op=instr[15:13]`; `S=instr[12:8]`; `J8=instr[7:0]`; `J5=instr[4:0]`.
- **Phase 0:** latch `instr_i` into `instr_o`.
- **Phase 1:** compute the next PC. `PC` is AW bits wide; `page` is AW−13 bits wide (absent when AW=13).
  - `op` 000–011 (ALU ops) and 110 (XMIT, non-command): `PC<=PC+1`, wrapping modulo 2^AW.
  - `op` 111 (JMP): `PC<={page,instr[12:0]}`.
  - `op` 101 (NZT): if `src_value_i!=0`, branch:
    - `S[4]=1`: `PC<={PC[AW-1:5],J5}`.
    - `S[4]=0`: `PC<={PC[AW-1:8],J8}`.
    - Otherwise `PC+1`.
  - `op` 100 (XEC): PC unchanged. Latch `xtgt`, with no carry out of the field:
    - `S[4]=1`: `{PC[AW-1:5], (src_value_i[4:0]+J5) mod 32}`.
    - `S[4]=0`: `{PC[AW-1:8], (src_value_i+J8) mod 256}`.
  - Command **CALL**, `instr[15:8]=8'hC9`: push `PC+1`; `PC<={PC[AW-1:8],J8}`.
  - Command **RET**, `instr[15:8]=8'hCD`: pop into PC. If the stack is empty: `PC<=PC+1`, set `stk_unf_o`.
  - Command **SETPAGE**, `instr[15:8]=8'hCE`: `page<=J8[AW-14:0]`; `PC<=PC+1`. When AW=13, SETPAGE acts as a plain `PC+1`.
- **Phase 2:** `A<=` `xtgt` if the instruction is XEC, else the new `PC`.
- **Phase 3:** memory access.
  - Without waits, or with `ready_i=1`: next phase is 0.
  - Otherwise phase 3 holds.
- **Stack:**
  - Circular, with pointer `sp` in 0..STACK_DEPTH.
  - A push while full overwrites the oldest entry, leaves `sp` at full and sets `stk_ovf_o`.
  - Flags clear only on reset.
- **XEC return:** the instruction fetched by XEC, if non-branching, advances the unchanged PC. Execution therefore resumes at XEC+1.

## Timing
- A machine cycle is 4 clocks, plus N wait clocks in phase 3.
- `A` changes on the edge that ends phase 2. It is valid for the whole of phase 3 and the following phase 0.
- `instr_o` updates on the edge ending phase 0.
- `src_value_i` must be stable at the edge ending phase 1.
- Reset values: `phase_o=0`, `PC=0`, `A=0`, `page=0`, `sp=0`, `instr_o=0`, `mclk_o=0`, `stk_ovf_o=0`, `stk_unf_o=0`.
- The first fetch is address 0.
- Reset asserted in any phase, including wait states, returns everything to reset values on the next edge. Stack contents are discarded.
- First-instruction latency after reset release: `instr_i` is sampled 1 clock after release.

## Configuration
- `IVX_WAIT_EN` defined: `ready_i=0` during phase 3 holds phase 3, keeping `mclk_o` high and `A` stable, for as many clocks as `ready_i` stays low.
- `IVX_WAIT_EN` undefined: `ready_i` is ignored; every cycle is exactly 4 clocks.

## Test plan
- **Reset then ALU ops:** reset, then instruction 16'h0000 at every fetch. Required: `A` sequence 0,1,2,…; `mclk_o` high one clock in four; `A` wraps 8191→0 at AW=13.
- **JMP with page:** AW=16, SETPAGE with J8=8'h05, then JMP 13'h0123. Required: `A=16'hA123`.
- **NZT:**
  - PC=0x0210, S=5'h02, J8=8'h40, `src_value_i=0`: required `A=0x211`.
  - Same with `src_value_i=1`: required `A=0x240`.
  - `S[4]=1`, J5=5'h1F: required `A=0x21F`.
- **XEC:** PC=0x0310, `S[4]=0`, J8=8'hF0, `src_value_i=8'h20`. Required: `A=0x310` (in-page wrap); PC unchanged; after a following ALU op, `A=0x311`.
- **CALL/RET:** STACK_DEPTH=4.
  - 5 nested CALLs: `stk_ovf_o=1`.
  - 4 RETs return to the 4 newest return addresses.
  - 5th RET: PC+1, `stk_unf_o=1`.
- **Waits (IVX_WAIT_EN):** hold `ready_i=0` for 3 clocks in phase 3. Required: cycle length 7 clocks, `A` stable throughout. Reset asserted during the wait returns `phase_o=0`, `A=0` next edge.
